load_store_unit: RTL

- Memory-access stage directly downstream of the ALU.
- Consumes the effective address computed by the ALU for LOAD/STORE opcodes, plus rs2 data and funct3.
- Runs a request/grant/response transaction with the data memory: byte-lane steering and byte enables for stores, lane extraction and sign/zero extension for loads.
- Returns the load result to writeback with a one-cycle done pulse; detects misaligned and illegal-width accesses without touching memory.

---
 rtl/load_store_unit_pkg.sv | 47 ++++
 rtl/load_store_unit_align.sv | 54 +++++
 rtl/load_store_unit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store stage: opcodes, access widths, FSM states.
// Latency: n/a (types and pure helper functions only).
// Backpressure: n/a.
package load_store_unit_pkg;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_t;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_width_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_FAULT
    } lsu_state_t;

    // Stores have no unsigned forms, so any funct3[2] is illegal for them.
    function automatic logic lsu_illegal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return f3[2] || (f3 == 3'b011);
        else
            return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Only meaningful for legal widths; illegal ones are caught first.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return ((f3[1:0] == 2'b01) && off[0]) || ((f3 == 3'b010) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering: store enables/replicated data and load shift/extend.
// Latency: purely combinational.
// Backpressure: none; follows its inputs.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  st_width,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [2:0]  ld_width,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ldata
);

    // Only the low halfword of the shifted read word is ever needed.
    logic [15:0] sh;
    assign sh = 16'(rdata >> {ld_off, 3'b000});

    // Store lanes: replicate the datum across the word, enable only the target lanes.
    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        case (st_width)
            MEM_B, MEM_BU: begin
                be    = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            MEM_H, MEM_HU: begin
                be    = 4'b0011 << st_off;
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    // Load result: pick the addressed lane(s) and extend to 32 bits.
    always_comb begin
        ldata = rdata;
        case (ld_width)
            MEM_B:   ldata = {{24{sh[7]}}, sh[7:0]};
            MEM_H:   ldata = {{16{sh[15]}}, sh[15:0]};
            MEM_BU:  ldata = {24'h0, sh[7:0]};
            MEM_HU:  ldata = {16'h0, sh[15:0]};
            default: ldata = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: runs req/gnt/rvalid with data memory for RV32I loads and stores.
// Latency: store done 2 cycles after start with immediate grant; load 3; faults 1.
// Backpressure: holds mem_req and all mem_* stable until mem_gnt; ignores start while busy.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  opcode_t     opcode,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault_misaligned,
    output logic        fault_illegal,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_off;

    logic        launch;
    logic        is_store;
    logic        acc_illegal;
    logic        acc_misaligned;
    logic [3:0]  a_be;
    logic [31:0] a_wdata;
    logic [31:0] a_ldata;

    assign is_store       = (opcode == OP_STORE);
    assign launch         = start && ((opcode == OP_LOAD) || is_store);
    assign acc_illegal    = lsu_illegal(is_store, funct3);
    assign acc_misaligned = lsu_misaligned(funct3, addr[1:0]);

    // Store steering uses the live inputs (captured at launch); load extraction
    // uses the latched width/offset against the returning read word.
    lsu_align u_align (
        .st_width (funct3),
        .st_off   (addr[1:0]),
        .st_data  (store_data),
        .be       (a_be),
        .wdata    (a_wdata),
        .ld_width (lat_f3),
        .ld_off   (lat_off),
        .rdata    (mem_rdata),
        .ldata    (a_ldata)
    );

    // Transaction FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            lat_f3           <= 3'b000;
            lat_off          <= 2'b00;
            busy             <= 1'b0;
            done             <= 1'b0;
            load_data        <= 32'h0;
            fault_misaligned <= 1'b0;
            fault_illegal    <= 1'b0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= 32'h0;
            mem_be           <= 4'b0000;
            mem_wdata        <= 32'h0;
        end else begin
            done             <= 1'b0;
            fault_misaligned <= 1'b0;
            fault_illegal    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (launch) begin
                        busy    <= 1'b1;
                        lat_f3  <= funct3;
                        lat_off <= addr[1:0];
                        mem_we  <= is_store;
                        if (acc_illegal || acc_misaligned) begin
                            // Illegal wins; never raise both fault bits.
                            state            <= S_FAULT;
                            done             <= 1'b1;
                            fault_illegal    <= acc_illegal;
                            fault_misaligned <= !acc_illegal;
                        end else begin
                            state     <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= a_be;
                            mem_wdata <= a_wdata;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_we) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        load_data <= a_ldata;
                        state     <= S_DONE;
                        done      <= 1'b1;
                    end
                end
                S_DONE, S_FAULT: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
